xbar_input_arbiter: RTL

//  Shares one action-stage crossbar between NUM_REQ PHV/action sources (e.g. parser and recirculation).

---
 rtl/xbar_input_arbiter.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/xbar_input_arbiter.sv
// xbar_input_arbiter
// Shares one action-stage crossbar between NUM_REQ PHV/action sources.
// Each source owns a one-deep hold register. A round-robin pick feeds
// registered phv/action/valid outputs into the crossbar. Issue is throttled
// by the crossbar handshake: a valid that meets dn_ready=0 halts the crossbar.
// After that, nothing more is issued until ready_out (xbar_ready) comes back.
module xbar_input_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int PHV_LEN    = 4*8*64+256,
  parameter int ACT_LEN    = 64,
  parameter int C_NUM_PHVS = 65,
  parameter int CNT_W      = 32,
  localparam int ACT_W     = ACT_LEN*C_NUM_PHVS,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ*PHV_LEN-1:0] req_phv,
  input  logic [NUM_REQ*ACT_W-1:0]   req_act,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [PHV_LEN-1:0]         xbar_phv,
  output logic [ACT_W-1:0]           xbar_act,
  output logic                       xbar_valid,
  input  logic                       xbar_ready,
  input  logic                       dn_ready,
  output logic [ID_W-1:0]            grant_id,
  output logic [CNT_W-1:0]           issue_cnt,
  output logic [CNT_W-1:0]           stall_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SENT  = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Flattened views of the per-requester hold registers.
  logic [NUM_REQ-1:0]         held;
  logic [NUM_REQ*PHV_LEN-1:0] hold_phv;
  logic [NUM_REQ*ACT_W-1:0]   hold_act;

  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] win_id;
  logic            win_found;
  logic            issue;

  logic               xbar_valid_q, xbar_valid_d;
  logic [PHV_LEN-1:0] xbar_phv_q, xbar_phv_d;
  logic [ACT_W-1:0]   xbar_act_q, xbar_act_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  // One hold slot per requester. Loading is only possible while the slot is
  // empty, so a slot that is being issued cannot reload until the next cycle.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    logic               held_q, held_d;
    logic [PHV_LEN-1:0] phv_q, phv_d;
    logic [ACT_W-1:0]   act_q, act_d;
    logic               accept;
    logic               issued;

    assign accept = req_valid[gi] & ~held_q;
    assign issued = issue & (win_id == ID_W'(gi));

    // Slot next-state: clear when issued, load when a new pair is accepted.
    always_comb begin
      held_d = held_q;
      phv_d  = phv_q;
      act_d  = act_q;
      if (issued) begin
        held_d = 1'b0;
      end
      if (accept) begin
        held_d = 1'b1;
        phv_d  = req_phv[gi*PHV_LEN +: PHV_LEN];
        act_d  = req_act[gi*ACT_W +: ACT_W];
      end
    end

    // Occupancy flag; reset drops any pair still waiting.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        held_q <= 1'b0;
      end else begin
        held_q <= held_d;
      end
    end

    // Payload needs no reset: it is only observed while held_q is set.
    always_ff @(posedge clk) begin
      phv_q <= phv_d;
      act_q <= act_d;
    end

    assign held[gi]                         = held_q;
    assign hold_phv[gi*PHV_LEN +: PHV_LEN]  = phv_q;
    assign hold_act[gi*ACT_W +: ACT_W]      = act_q;
    assign req_ready[gi]                    = ~held_q;
  end

  // Round-robin search: the first held slot at or after rr_ptr wins.
  always_comb begin : rr_search
    int              idx;
    logic [ID_W-1:0] cand;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      cand = ID_W'(idx);
      if (!win_found && held[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // Crossbar handshake FSM. It decides whether this edge may issue.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        issue = xbar_ready & win_found;
        if (issue) begin
          state_d = ST_SENT;
        end
      end
      ST_SENT: begin
        // The valid presented this cycle is taken cleanly only if the ALU is ready.
        if (dn_ready) begin
          issue   = win_found;
          state_d = issue ? ST_SENT : ST_IDLE;
        end else begin
          state_d = ST_STALL;
        end
      end
      ST_STALL: begin
        // Leave on ready_out, but do not issue on the same edge.
        if (xbar_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output staging, pointer advance and saturating counters.
  always_comb begin
    xbar_valid_d = issue;
    xbar_phv_d   = xbar_phv_q;
    xbar_act_d   = xbar_act_q;
    grant_id_d   = grant_id_q;
    rr_ptr_d     = rr_ptr_q;
    issue_cnt_d  = issue_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (issue) begin
      xbar_phv_d = hold_phv[int'(win_id)*PHV_LEN +: PHV_LEN];
      xbar_act_d = hold_act[int'(win_id)*ACT_W +: ACT_W];
      grant_id_d = win_id;
      if (int'(win_id) + 1 >= NUM_REQ) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = win_id + 1'b1;
      end
      if (issue_cnt_q != {CNT_W{1'b1}}) begin
        issue_cnt_d = issue_cnt_q + 1'b1;
      end
    end
    if (state_q == ST_STALL && stall_cnt_q != {CNT_W{1'b1}}) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State, pointer, output and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      xbar_valid_q <= 1'b0;
      xbar_phv_q   <= '0;
      xbar_act_q   <= '0;
      grant_id_q   <= '0;
      issue_cnt_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      xbar_valid_q <= xbar_valid_d;
      xbar_phv_q   <= xbar_phv_d;
      xbar_act_q   <= xbar_act_d;
      grant_id_q   <= grant_id_d;
      issue_cnt_q  <= issue_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign xbar_valid = xbar_valid_q;
  assign xbar_phv   = xbar_phv_q;
  assign xbar_act   = xbar_act_q;
  assign grant_id   = grant_id_q;
  assign issue_cnt  = issue_cnt_q;
  assign stall_cnt  = stall_cnt_q;

endmodule
